// File: rtl/exu_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR map and FSM states.
package exu_trap_ctrl_pkg;

    // Machine-mode CSR addresses served by the trap controller
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    // Redirect FSM: idle, or holding a flush until the IFU takes it
    typedef enum logic {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } state_e;

endpackage

// File: rtl/exu_cnt64.sv
// 64-bit free-running mcycle counter with independent low/high half write ports.
// A write to either half replaces it and suppresses that cycle's increment.
module exu_cnt64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_cnt
);

    logic [63:0] r_cnt;

    // Count every cycle unless software is writing one of the halves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_wr_lo) begin
            r_cnt[31:0] <= i_wdata;
        end else if (i_wr_hi) begin
            r_cnt[63:32] <= i_wdata;
        end else begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/exu_trap_ctrl.sv
// Machine-mode trap controller: updates trap CSRs on committed traps/mret,
// issues one registered redirect to the IFU, and serves the CSR access port.
module exu_trap_ctrl
    import exu_trap_ctrl_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_i_valid,
    output logic            trap_i_ready,
    input  logic [XLEN-1:0] trap_i_cause,
    input  logic [XLEN-1:0] trap_i_pc,
    input  logic [XLEN-1:0] trap_i_tval,
    input  logic            mret_i_valid,
    output logic            mret_i_ready,
    input  logic            csr_i_ena,
    input  logic            csr_i_wr,
    input  logic [11:0]     csr_i_addr,
    input  logic [XLEN-1:0] csr_i_wdata,
    output logic [XLEN-1:0] csr_o_rdata,
    output logic            flush_o_valid,
    input  logic            flush_i_ready,
    output logic [XLEN-1:0] flush_o_pc,
    output logic            status_o_mie
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_e          r_state;
    logic [XLEN-1:0] r_flush_pc;
    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic            w_idle;
    logic            w_trap_acc;
    logic            w_mret_acc;
    logic            w_csr_we;
    logic [63:0]     w_cnt;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_rdata;

    assign w_idle     = (r_state == StIdle);
    assign w_trap_acc = w_idle & trap_i_valid;
    assign w_mret_acc = w_idle & mret_i_valid & ~trap_i_valid;
    // The instruction behind a CSR write is being flushed if a trap/mret is taken or pending
    assign w_csr_we   = csr_i_ena & csr_i_wr & w_idle & ~w_trap_acc & ~w_mret_acc;

    assign trap_i_ready  = w_idle;
    assign mret_i_ready  = w_idle & ~trap_i_valid;
    assign flush_o_valid = (r_state == StFlush);
    assign flush_o_pc    = r_flush_pc;
    assign status_o_mie  = r_mie;

    // Redirect FSM; the target is captured at accept and held for the whole FLUSH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_flush_pc <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_trap_acc) begin
                        r_state    <= StFlush;
                        r_flush_pc <= r_mtvec;
                    end else if (w_mret_acc) begin
                        r_state    <= StFlush;
                        r_flush_pc <= r_mepc;
                    end
                end
                StFlush: begin
                    if (flush_i_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Trap CSR state: trap/mret side effects, otherwise software writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtvec  <= MTVEC_RST & ALIGN_MASK;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (w_trap_acc) begin
            r_mepc   <= trap_i_pc & ALIGN_MASK;
            r_mcause <= trap_i_cause;
            r_mtval  <= trap_i_tval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_mret_acc) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
        end else if (w_csr_we) begin
            case (csr_i_addr)
                CSR_MSTATUS: begin
                    r_mie  <= csr_i_wdata[MSTATUS_MIE];
                    r_mpie <= csr_i_wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:  r_mtvec  <= csr_i_wdata & ALIGN_MASK;
                CSR_MEPC:   r_mepc   <= csr_i_wdata & ALIGN_MASK;
                CSR_MCAUSE: r_mcause <= csr_i_wdata;
                CSR_MTVAL:  r_mtval  <= csr_i_wdata;
                default: ;
            endcase
        end
    end

    exu_cnt64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_wr_lo (w_csr_we & (csr_i_addr == CSR_MCYCLE)),
        .i_wr_hi (w_csr_we & (csr_i_addr == CSR_MCYCLEH)),
        .i_wdata (csr_i_wdata[31:0]),
        .o_cnt   (w_cnt)
    );

    // mstatus view: MPP hard-wired to machine mode, only MIE/MPIE live
    always_comb begin
        w_mstatus               = '0;
        w_mstatus[12:11]        = 2'b11;
        w_mstatus[MSTATUS_MPIE] = r_mpie;
        w_mstatus[MSTATUS_MIE]  = r_mie;
    end

    // Combinational CSR read mux; unmapped addresses read zero
    always_comb begin
        w_rdata = '0;
        case (csr_i_addr)
            CSR_MSTATUS: w_rdata = w_mstatus;
            CSR_MTVEC:   w_rdata = r_mtvec;
            CSR_MEPC:    w_rdata = r_mepc;
            CSR_MCAUSE:  w_rdata = r_mcause;
            CSR_MTVAL:   w_rdata = r_mtval;
            CSR_MCYCLE:  w_rdata = XLEN'(w_cnt[31:0]);
            CSR_MCYCLEH: w_rdata = XLEN'(w_cnt[63:32]);
            default:     w_rdata = '0;
        endcase
    end

    assign csr_o_rdata = w_rdata;

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Bench for exu_trap_ctrl: directed stimulus, a cycle model of the trap/CSR
// rules checked every cycle, plus literal expectations at key points.
module tb_exu_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        trap_i_valid;
    logic        trap_i_ready;
    logic [31:0] trap_i_cause;
    logic [31:0] trap_i_pc;
    logic [31:0] trap_i_tval;
    logic        mret_i_valid;
    logic        mret_i_ready;
    logic        csr_i_ena;
    logic        csr_i_wr;
    logic [11:0] csr_i_addr;
    logic [31:0] csr_i_wdata;
    logic [31:0] csr_o_rdata;
    logic        flush_o_valid;
    logic        flush_i_ready;
    logic [31:0] flush_o_pc;
    logic        status_o_mie;

    int n_checks = 0;
    int n_fail   = 0;

    exu_trap_ctrl #(
        .XLEN      (32),
        .MTVEC_RST (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trap_i_valid  (trap_i_valid),
        .trap_i_ready  (trap_i_ready),
        .trap_i_cause  (trap_i_cause),
        .trap_i_pc     (trap_i_pc),
        .trap_i_tval   (trap_i_tval),
        .mret_i_valid  (mret_i_valid),
        .mret_i_ready  (mret_i_ready),
        .csr_i_ena     (csr_i_ena),
        .csr_i_wr      (csr_i_wr),
        .csr_i_addr    (csr_i_addr),
        .csr_i_wdata   (csr_i_wdata),
        .csr_o_rdata   (csr_o_rdata),
        .flush_o_valid (flush_o_valid),
        .flush_i_ready (flush_i_ready),
        .flush_o_pc    (flush_o_pc),
        .status_o_mie  (status_o_mie)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_mie, m_mpie, m_pend;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_fpc;
    logic [63:0] m_cyc;
    bit          t_acc, r_acc, we;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_mie = 0; m_mpie = 0; m_pend = 0;
                m_mtvec = 32'h8000_0000; m_mepc = 0; m_mcause = 0; m_mtval = 0;
                m_fpc = 0; m_cyc = 0;
            end else begin
                t_acc = !m_pend && trap_i_valid;
                r_acc = !m_pend && mret_i_valid && !trap_i_valid;
                we    = csr_i_ena && csr_i_wr && !m_pend && !t_acc && !r_acc;
                if (we && csr_i_addr == 12'hB00)      m_cyc[31:0]  = csr_i_wdata;
                else if (we && csr_i_addr == 12'hB80) m_cyc[63:32] = csr_i_wdata;
                else                                  m_cyc        = m_cyc + 64'd1;
                if (we) begin
                    case (csr_i_addr)
                        12'h300: begin m_mie = csr_i_wdata[3]; m_mpie = csr_i_wdata[7]; end
                        12'h305: m_mtvec  = csr_i_wdata & 32'hFFFF_FFFC;
                        12'h341: m_mepc   = csr_i_wdata & 32'hFFFF_FFFC;
                        12'h342: m_mcause = csr_i_wdata;
                        12'h343: m_mtval  = csr_i_wdata;
                        default: ;
                    endcase
                end
                if (t_acc) begin
                    m_mepc = trap_i_pc & 32'hFFFF_FFFC;
                    m_mcause = trap_i_cause;
                    m_mtval = trap_i_tval;
                    m_mpie = m_mie;
                    m_mie = 0;
                    m_fpc = m_mtvec;
                    m_pend = 1;
                end else if (r_acc) begin
                    m_mie = m_mpie;
                    m_mpie = 1;
                    m_fpc = m_mepc;
                    m_pend = 1;
                end else if (m_pend && flush_i_ready) begin
                    m_pend = 0;
                end
            end
        end
    end

    // Per-cycle compare, midway between active edges
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("m_fvalid", 32'(flush_o_valid), 32'(m_pend));
                chk("m_fpc", flush_o_pc, m_fpc);
                chk("m_mie", 32'(status_o_mie), 32'(m_mie));
                chk("m_trdy", 32'(trap_i_ready), 32'(!m_pend));
                chk("m_mrdy", 32'(mret_i_ready), 32'(!m_pend && !trap_i_valid));
                if (csr_i_ena) chk("m_rdata", csr_o_rdata, m_read(csr_i_addr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        trap_i_valid = 0; trap_i_cause = 0; trap_i_pc = 0; trap_i_tval = 0;
        mret_i_valid = 0; csr_i_ena = 0; csr_i_wr = 0; csr_i_addr = 0; csr_i_wdata = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_i_ena = 1; csr_i_wr = 1; csr_i_addr = a; csr_i_wdata = d;
        tick();
        csr_i_ena = 0; csr_i_wr = 0;
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] e, input string name);
        csr_i_ena = 1; csr_i_wr = 0; csr_i_addr = a;
        #1;
        chk(name, csr_o_rdata, e);
    endtask

    logic [31:0] v1;

    initial begin
        rst = 0;
        clr();
        flush_i_ready = 1;
        repeat (3) tick();
        rst = 1;

        // Reset state
        rd_chk(12'h305, 32'h8000_0000, "rst_mtvec");
        chk("rst_fvalid", 32'(flush_o_valid), 0);
        chk("rst_fpc", flush_o_pc, 0);
        chk("rst_mie", 32'(status_o_mie), 0);
        rd_chk(12'h341, 32'h0, "rst_mepc");
        tick();
        csr_i_addr = 12'hB00;
        #1 v1 = csr_o_rdata;
        tick();
        #1 chk("cyc_inc", csr_o_rdata - v1, 32'd1);
        clr();

        // Ebreak trap with MIE=1 and a misaligned mtvec write
        wr(12'h300, 32'h0000_0008);
        wr(12'h305, 32'h8000_0201);
        rd_chk(12'h305, 32'h8000_0200, "mtvec_mask");
        clr();
        flush_i_ready = 0;
        trap_i_valid = 1; trap_i_cause = 3; trap_i_pc = 32'h8000_0106; trap_i_tval = 32'h55;
        #1 chk("trap_rdy", 32'(trap_i_ready), 1);
        tick();
        clr();
        chk("trap_fvalid", 32'(flush_o_valid), 1);
        chk("trap_fpc", flush_o_pc, 32'h8000_0200);
        chk("trap_mie", 32'(status_o_mie), 0);
        rd_chk(12'h341, 32'h8000_0104, "trap_mepc");
        rd_chk(12'h342, 32'd3, "trap_mcause");
        rd_chk(12'h343, 32'h55, "trap_mtval");
        rd_chk(12'h300, 32'h0000_1880, "trap_mstatus");

        // Backpressure: second trap waits for IDLE
        trap_i_valid = 1; trap_i_cause = 11; trap_i_pc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_trdy", 32'(trap_i_ready), 0);
            chk("bp_fvalid", 32'(flush_o_valid), 1);
            chk("bp_fpc", flush_o_pc, 32'h8000_0200);
            tick();
        end
        flush_i_ready = 1;
        #1 chk("bp_trdy_last", 32'(trap_i_ready), 0);
        tick();
        #1 chk("bp_trdy_idle", 32'(trap_i_ready), 1);
        tick();
        clr();
        rd_chk(12'h341, 32'h200, "bp_mepc");
        rd_chk(12'h342, 32'd11, "bp_mcause");
        rd_chk(12'h300, 32'h0000_1800, "bp_mstatus");
        tick();

        // Mret
        clr();
        wr(12'h341, 32'h8000_0010);
        wr(12'h300, 32'h0000_0080);
        mret_i_valid = 1;
        #1 chk("mret_rdy", 32'(mret_i_ready), 1);
        tick();
        clr();
        chk("mret_fpc", flush_o_pc, 32'h8000_0010);
        chk("mret_mie", 32'(status_o_mie), 1);
        rd_chk(12'h300, 32'h0000_1888, "mret_mstatus");
        tick();

        // Trap and mret together: trap wins
        clr();
        trap_i_valid = 1; trap_i_cause = 11; trap_i_pc = 32'h300; mret_i_valid = 1;
        #1 chk("both_mrdy", 32'(mret_i_ready), 0);
        tick();
        clr();
        chk("both_fpc", flush_o_pc, 32'h8000_0200);
        rd_chk(12'h341, 32'h300, "both_mepc");
        rd_chk(12'h300, 32'h0000_1880, "both_mstatus");
        tick();

        // Counter wrap
        clr();
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd_chk(12'hB80, 32'hFFFF_FFFF, "cyc_hi_ones");
        tick();
        rd_chk(12'hB00, 32'h0, "cyc_lo_wrap");
        tick();
        rd_chk(12'hB80, 32'h0, "cyc_hi_wrap");
        tick();

        // CSR write dropped in a trap-accept cycle
        clr();
        trap_i_valid = 1; trap_i_cause = 3; trap_i_pc = 32'h100;
        csr_i_ena = 1; csr_i_wr = 1; csr_i_addr = 12'h341; csr_i_wdata = 32'h1234;
        tick();
        clr();
        rd_chk(12'h341, 32'h100, "drop_mepc");
        tick();

        // Unmapped address
        clr();
        wr(12'h123, 32'hDEAD_BEEF);
        rd_chk(12'h123, 32'h0, "unmapped");

        // CSR write dropped while in FLUSH
        clr();
        flush_i_ready = 0;
        trap_i_valid = 1; trap_i_cause = 3; trap_i_pc = 32'h40; trap_i_tval = 32'h77;
        tick();
        clr();
        wr(12'h343, 32'h0000_AAAA);
        rd_chk(12'h343, 32'h77, "flush_drop");

        // Reset mid-FLUSH
        csr_i_addr = 12'h305;
        #1 rst = 0;
        #1;
        chk("rstf_fvalid", 32'(flush_o_valid), 0);
        chk("rstf_fpc", flush_o_pc, 0);
        rd_chk(12'h343, 32'h0, "rstf_mtval");
        tick();
        flush_i_ready = 1;
        rst = 1;
        clr();
        tick();
        chk("post_rst_fvalid", 32'(flush_o_valid), 0);
        chk("post_rst_trdy", 32'(trap_i_ready), 1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
